pulse_train_ctrl: RTL

Avalon-MM-configured pulse-train sequencer for the HPS-to-FPGA blink path. A start request comes from the rising edge of the single-bit start PIO output or from a software write. The block then drives `pulse_out` high and low for programmed cycle counts, repeating for a programmed number of pulses or continuously until aborted. It sits between the lightweight-bridge PIO peripherals and the LED/GPIO pins, and reports busy/done status and a completion interrupt.

---
 rtl/pulse_train_pkg.sv | 24 ++
 rtl/pt_down_counter.sv | 36 +++
 rtl/pulse_train_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse-train sequencer: FSM state encoding,
// Avalon register map and CTRL/STATUS bit positions.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } pt_state_t;

    localparam logic [1:0] PT_ADDR_HIGH = 2'd0;
    localparam logic [1:0] PT_ADDR_LOW  = 2'd1;
    localparam logic [1:0] PT_ADDR_NUM  = 2'd2;
    localparam logic [1:0] PT_ADDR_CTRL = 2'd3;

    localparam int unsigned CTRL_GO_BIT      = 0;
    localparam int unsigned CTRL_ABORT_BIT   = 1;
    localparam int unsigned CTRL_IRQ_CLR_BIT = 2;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_IRQ_BIT  = 2;

endpackage

// File: rtl/pt_down_counter.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module pt_down_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign zero_o  = (cnt_q == '0);
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_train_ctrl.sv
// Avalon-MM configured pulse-train sequencer: register file, start edge detect and
// IDLE/HIGH/LOW FSM driving pulse_out, with busy/done status and a sticky irq.
module pulse_train_ctrl
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        start_in,
    output logic        pulse_out,
    output logic        busy,
    output logic        irq
);

    pt_state_t state_q, state_d;

    logic [CNT_W-1:0] high_cyc_q, low_cyc_q;
    logic [NUM_W-1:0] num_pulses_q;
    logic [CNT_W-1:0] hm1_q, hm1_d, lm1_q, lm1_d;
    logic [CNT_W-1:0] h_snap, l_snap;
    logic             done_q, done_d, irq_q, irq_d, start_q;

    logic wr_en, ctrl_wr, go, abort, irq_clr, start_req, start_acc, run_end;

    logic             dur_load, dur_dec, dur_zero;
    logic [CNT_W-1:0] dur_val, dur_count;
    logic             pc_load, pc_dec, pc_zero;
    logic [NUM_W-1:0] pc_count;
    logic             unused_dur_count;

    assign wr_en   = chipselect & ~write_n;
    assign ctrl_wr = wr_en & (address == PT_ADDR_CTRL);
    assign go      = ctrl_wr & writedata[CTRL_GO_BIT];
    assign abort   = ctrl_wr & writedata[CTRL_ABORT_BIT];
    assign irq_clr = ctrl_wr & writedata[CTRL_IRQ_CLR_BIT];

    assign start_req = (start_in & ~start_q) | go;
    assign start_acc = (state_q == StIdle) & start_req & ~abort;

    // A programmed duration of 0 behaves as 1; counters hold duration-1.
    assign h_snap = (high_cyc_q == '0) ? '0 : high_cyc_q - CNT_W'(1);
    assign l_snap = (low_cyc_q == '0) ? '0 : low_cyc_q - CNT_W'(1);

    assign pulse_out        = (state_q == StHigh);
    assign busy             = (state_q != StIdle);
    assign irq              = irq_q;
    assign unused_dur_count = ^dur_count;

    pt_down_counter #(.Width(CNT_W)) u_dur_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (dur_load),
        .load_val_i (dur_val),
        .dec_i      (dur_dec),
        .count_o    (dur_count),
        .zero_o     (dur_zero)
    );

    pt_down_counter #(.Width(NUM_W)) u_pulse_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (pc_load),
        .load_val_i (num_pulses_q),
        .dec_i      (pc_dec),
        .count_o    (pc_count),
        .zero_o     (pc_zero)
    );

    always_comb begin
        state_d  = state_q;
        hm1_d    = hm1_q;
        lm1_d    = lm1_q;
        dur_load = 1'b0;
        dur_val  = lm1_q;
        dur_dec  = 1'b0;
        pc_load  = 1'b0;
        pc_dec   = 1'b0;
        run_end  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d  = StHigh;
                    hm1_d    = h_snap;
                    lm1_d    = l_snap;
                    dur_load = 1'b1;
                    dur_val  = h_snap;
                    pc_load  = 1'b1;
                end
            end
            StHigh: begin
                if (dur_zero) begin
                    state_d  = StLow;
                    dur_load = 1'b1;
                    dur_val  = lm1_q;
                end else begin
                    dur_dec = 1'b1;
                end
            end
            StLow: begin
                if (dur_zero) begin
                    pc_dec = 1'b1;
                    // A zero pulse count means continuous mode: never ends by itself.
                    if (!pc_zero && (pc_count == NUM_W'(1))) begin
                        state_d = StIdle;
                        run_end = 1'b1;
                    end else begin
                        state_d  = StHigh;
                        dur_load = 1'b1;
                        dur_val  = hm1_q;
                    end
                end else begin
                    dur_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            run_end = 1'b0;
        end

        done_d = done_q;
        if (start_acc) begin
            done_d = 1'b0;
        end else if (run_end) begin
            done_d = 1'b1;
        end
        irq_d = irq_q;
        if (run_end) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            high_cyc_q   <= '0;
            low_cyc_q    <= '0;
            num_pulses_q <= '0;
            hm1_q        <= '0;
            lm1_q        <= '0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            hm1_q   <= hm1_d;
            lm1_q   <= lm1_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            start_q <= start_in;
            if (wr_en && (address == PT_ADDR_HIGH)) high_cyc_q   <= writedata[CNT_W-1:0];
            if (wr_en && (address == PT_ADDR_LOW))  low_cyc_q    <= writedata[CNT_W-1:0];
            if (wr_en && (address == PT_ADDR_NUM))  num_pulses_q <= writedata[NUM_W-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            PT_ADDR_HIGH: readdata[CNT_W-1:0] = high_cyc_q;
            PT_ADDR_LOW:  readdata[CNT_W-1:0] = low_cyc_q;
            PT_ADDR_NUM:  readdata[NUM_W-1:0] = num_pulses_q;
            PT_ADDR_CTRL: begin
                readdata[STAT_BUSY_BIT] = busy;
                readdata[STAT_DONE_BIT] = done_q;
                readdata[STAT_IRQ_BIT]  = irq_q;
            end
            default: readdata = '0;
        endcase
    end

endmodule
